// File: rtl/dmem_lane_arbiter.sv
// Round-robin front end for the four byte-lane data banks.
// Steers byte/half/word accesses at any alignment; each response follows its grant by one cycle.
module dmem_lane_arbiter #(
  parameter int unsigned DEPTH = 8192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a_req,
  input  logic         a_we,
  input  logic [1:0]   a_size,
  input  logic         a_unsigned,
  input  logic [31:0]  a_addr,
  input  logic [31:0]  a_wdata,
  output logic         a_gnt,
  output logic         a_rvalid,
  output logic [31:0]  a_rdata,
  output logic         a_err,
  input  logic         b_req,
  input  logic         b_we,
  input  logic [1:0]   b_size,
  input  logic         b_unsigned,
  input  logic [31:0]  b_addr,
  input  logic [31:0]  b_wdata,
  output logic         b_gnt,
  output logic         b_rvalid,
  output logic [31:0]  b_rdata,
  output logic         b_err,
  output logic [3:0]   bank_we,
  output logic [127:0] bank_num,
  output logic [31:0]  bank_wdata,
  input  logic [31:0]  bank_rdata
);

  localparam int unsigned LANES = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned XW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned IW    = AW - 2;

  logic          last_b;
  logic          any_gnt;
  logic          req_we;
  logic          req_uns;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [XW-1:0] req_wdata;
  logic [2:0]    req_n;
  logic [IW:0]   req_last;
  logic          req_err;

  logic [LANES-1:0][1:0]    lane_k;
  logic [LANES-1:0][IW-1:0] lane_idx;

  logic          vld_q;
  logic          own_b_q;
  logic          uns_q;
  logic          load_q;
  logic          err_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;

  logic [LANES-1:0][1:0] rd_lane;
  logic [XW-1:0]         rd_raw;
  logic [XW-1:0]         rd_data;

  // Round-robin: a contested cycle goes to whoever was not granted last.
  always_comb begin
    a_gnt   = ~rst & a_req & (~b_req | last_b);
    b_gnt   = ~rst & b_req & (~a_req | ~last_b);
    any_gnt = a_gnt | b_gnt;
  end

  // Selected request and its error check; req_last holds {overflow, index of last byte}.
  always_comb begin
    req_we    = b_gnt ? b_we       : a_we;
    req_uns   = b_gnt ? b_unsigned : a_unsigned;
    req_size  = b_gnt ? b_size     : a_size;
    req_addr  = b_gnt ? b_addr     : a_addr;
    req_wdata = b_gnt ? b_wdata    : a_wdata;
    case (req_size)
      2'd0:    req_n = 3'd1;
      2'd1:    req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
    req_last = {1'b0, req_addr[AW-1:2]}
             + (IW+1)'((3'(req_addr[1:0]) + req_n - 3'd1) >> 2);
    req_err  = (req_size == 2'd3) | req_last[IW] | (XW'(req_last[IW-1:0]) >= DEPTH);
  end

  // Lane j carries byte k = j - addr[1:0]; lanes below the start offset wrap into the next word.
  always_comb begin
    bank_we    = '0;
    bank_num   = '0;
    bank_wdata = '0;
    lane_k     = '0;
    lane_idx   = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_k[j]   = 2'(j) - req_addr[1:0];
      lane_idx[j] = req_addr[AW-1:2] + IW'(2'(j) < req_addr[1:0]);
      bank_num[XW*j +: XW] = XW'(req_addr[AW-1:2]);
      if (3'(lane_k[j]) < req_n) begin
        bank_num[XW*j +: XW]   = XW'(lane_idx[j]);
        bank_wdata[BW*j +: BW] = req_wdata[BW*lane_k[j] +: BW];
        bank_we[j]             = any_gnt & req_we & ~req_err;
      end
    end
  end

  // Response context captured at grant; rst discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_b  <= 1'b1;
      vld_q   <= 1'b0;
      own_b_q <= 1'b0;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      vld_q <= any_gnt;
      if (any_gnt) begin
        last_b  <= b_gnt;
        own_b_q <= b_gnt;
        uns_q   <= req_uns;
        load_q  <= ~req_we;
        err_q   <= req_err;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
      end
    end
  end

  // Rotate bank bytes back to little-endian order, then extend.
  always_comb begin
    rd_raw  = '0;
    rd_data = '0;
    rd_lane = '0;
    for (int k = 0; k < LANES; k++) begin
      rd_lane[k]          = off_q + 2'(k);
      rd_raw[BW*k +: BW]  = bank_rdata[BW*rd_lane[k] +: BW];
    end
    case (size_q)
      2'd0:    rd_data = uns_q ? XW'(rd_raw[7:0])  : {{24{rd_raw[7]}},  rd_raw[7:0]};
      2'd1:    rd_data = uns_q ? XW'(rd_raw[15:0]) : {{16{rd_raw[15]}}, rd_raw[15:0]};
      2'd2:    rd_data = rd_raw;
      default: rd_data = '0;
    endcase
    if (!load_q || err_q) begin
      rd_data = '0;
    end
  end

  always_comb begin
    a_rvalid = vld_q & ~own_b_q & ~rst;
    b_rvalid = vld_q & own_b_q & ~rst;
    a_rdata  = a_rvalid ? rd_data : '0;
    b_rdata  = b_rvalid ? rd_data : '0;
    a_err    = a_rvalid & err_q;
    b_err    = b_rvalid & err_q;
  end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// Bench for dmem_lane_arbiter: behavioural bank memories plus a flat byte-addressed reference model.
module tb_dmem_lane_arbiter;

  localparam int unsigned DEPTH = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_req, a_we, a_unsigned, a_gnt, a_rvalid, a_err;
  logic [1:0]   a_size;
  logic [31:0]  a_addr, a_wdata, a_rdata;
  logic         b_req, b_we, b_unsigned, b_gnt, b_rvalid, b_err;
  logic [1:0]   b_size;
  logic [31:0]  b_addr, b_wdata, b_rdata;
  logic [3:0]   bank_we;
  logic [127:0] bank_num;
  logic [31:0]  bank_wdata;
  logic [31:0]  bank_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] bank_mem [4][DEPTH];
  bit [7:0] ref_mem  [4*DEPTH];

  always #5 clk = ~clk;

  dmem_lane_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_size(a_size), .a_unsigned(a_unsigned),
    .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_size(b_size), .b_unsigned(b_unsigned),
    .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .b_rdata(b_rdata), .b_err(b_err),
    .bank_we(bank_we), .bank_num(bank_num), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  // Four lane RAMs with a registered read port.
  always @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (bank_num[32*j +: 32] < DEPTH) begin
        bank_rdata[8*j +: 8] <= bank_mem[j][bank_num[32*j +: 32]];
        if (bank_we[j]) bank_mem[j][bank_num[32*j +: 32]] <= bank_wdata[8*j +: 8];
      end else begin
        bank_rdata[8*j +: 8] <= 8'h00;
      end
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [1:0] size);
    longint last;
    if (size == 2'd3) return 1'b1;
    last = {32'd0, addr};
    last = last + nbytes(size) - 1;
    return (last > 64'hFFFF_FFFF) || (last / 4 >= DEPTH);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
    int n = nbytes(size);
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(ref_mem[addr + k]) << (8 * k);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] wdata);
    for (int k = 0; k < nbytes(size); k++) ref_mem[addr + k] = wdata[8*k +: 8];
  endfunction

  // Expected bank-side view: byte k sits in lane (addr+k)%4 at index (addr+k)/4.
  function automatic void model_lanes(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] wdata, output logic [3:0] mask,
                                      output logic [127:0] num, output logic [31:0] wd,
                                      output logic [31:0] wd_mask);
    logic [31:0] p;
    mask = '0; wd = '0; wd_mask = '0;
    for (int j = 0; j < 4; j++) num[32*j +: 32] = addr / 4;
    for (int k = 0; k < nbytes(size); k++) begin
      p = addr + k;
      mask[p % 4]            = 1'b1;
      num[32*(p % 4) +: 32]  = p / 4;
      wd[8*(p % 4) +: 8]     = wdata[8*k +: 8];
      wd_mask[8*(p % 4) +: 8] = 8'hFF;
    end
  endfunction

  task automatic drive_a(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    a_req = 1'b1; a_we = we; a_size = size; a_unsigned = uns; a_addr = addr; a_wdata = wdata;
    b_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b1; b_we = 1'b1;
    a_size = 2'd2; b_size = 2'd2; a_addr = 32'h0; b_addr = 32'h4;
    a_wdata = 32'h1234_5678; b_wdata = 32'h9ABC_DEF0;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt, bank_we} !== 6'b0) begin
      n_fail++; $display("FAIL reset_gnt_we: got %b expected 000000", {a_gnt, b_gnt, bank_we});
    end
    @(negedge clk);
    n_checks++;
    if ({a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata} !== 68'h0) begin
      n_fail++; $display("FAIL reset_resp: got a=%b/%b/%h b=%b/%b/%h expected all zero",
                         a_rvalid, a_err, a_rdata, b_rvalid, b_err, b_rdata);
    end
    rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_no_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
    end
  endtask

  task automatic test_directed();
    @(negedge clk);
    drive_a(1'b1, 2'd2, 1'b0, 32'h6, 32'hAABB_CCDD);
    #1;
    model_store(32'h6, 2'd2, 32'hAABB_CCDD);
    n_checks++;
    if ({a_gnt, bank_we} !== 5'b1_1111) begin
      n_fail++; $display("FAIL mis_store_we: got gnt=%b we=%b expected 1/1111", a_gnt, bank_we);
    end
    n_checks++;
    if (bank_num !== {32'd1, 32'd1, 32'd2, 32'd2}) begin
      n_fail++; $display("FAIL mis_store_num: got %h expected lanes3..0 = 1,1,2,2", bank_num);
    end
    n_checks++;
    if (bank_wdata !== 32'hCCDD_AABB) begin
      n_fail++; $display("FAIL mis_store_wdata: got %h expected ccddaabb", bank_wdata);
    end
    @(negedge clk);
    n_checks++;
    if ({a_rvalid, a_err, a_rdata, b_rvalid} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL store_resp: got v=%b e=%b d=%h bv=%b expected 1/0/0/0",
                         a_rvalid, a_err, a_rdata, b_rvalid);
    end
    drive_a(1'b0, 2'd2, 1'b0, 32'h6, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({a_rvalid, a_err, a_rdata} !== {1'b1, 1'b0, 32'hAABB_CCDD}) begin
      n_fail++; $display("FAIL mis_load_word: got v=%b e=%b d=%h expected 1/0/aabbccdd",
                         a_rvalid, a_err, a_rdata);
    end
    drive_a(1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
    @(negedge clk);
    n_checks++;
    if (a_rdata !== 32'hFFFF_FFCC) begin
      n_fail++; $display("FAIL load_byte_signed: got %h expected ffffffcc", a_rdata);
    end
    drive_a(1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
    @(negedge clk);
    n_checks++;
    if (a_rdata !== 32'h0000_00CC) begin
      n_fail++; $display("FAIL load_byte_unsigned: got %h expected 000000cc", a_rdata);
    end
    drive_a(1'b0, 2'd1, 1'b0, 32'h5, 32'h0);
    @(negedge clk);
    n_checks++;
    if (a_rdata !== 32'hFFFF_DD00) begin
      n_fail++; $display("FAIL load_half_signed: got %h expected ffffdd00", a_rdata);
    end
    a_req = 1'b0;
  endtask

  task automatic test_arbitration();
    logic prev_b;
    do_reset();
    prev_b = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if ({a_rvalid, b_rvalid} !== {~prev_b, prev_b}) begin
          n_fail++; $display("FAIL arb_rvalid_%0d: got a=%b b=%b expected a=%b b=%b",
                             i, a_rvalid, b_rvalid, ~prev_b, prev_b);
        end
      end
      if (i < 6) begin
        a_req = 1'b1; a_we = 1'b0; a_size = 2'd2; a_unsigned = 1'b0; a_addr = 32'h0;
        b_req = 1'b1; b_we = 1'b0; b_size = 2'd2; b_unsigned = 1'b0; b_addr = 32'h4;
        #1;
        n_checks++;
        if ({a_gnt, b_gnt} !== {i % 2 == 0, i % 2 == 1}) begin
          n_fail++; $display("FAIL arb_gnt_%0d: got a=%b b=%b expected a=%b b=%b",
                             i, a_gnt, b_gnt, i % 2 == 0, i % 2 == 1);
        end
        prev_b = (i % 2 == 1);
      end else begin
        a_req = 1'b0; b_req = 1'b0;
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [5];
    logic [1:0]  sizes [5];
    logic        wes   [5];
    logic        errs  [5];
    logic [31:0] exp_rd;
    logic        exp_e;
    addrs = '{32'(4*DEPTH - 2), 32'h10, 32'hFFFF_FFFE, 32'(4*DEPTH - 4), 32'(4*DEPTH - 4)};
    sizes = '{2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
    wes   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    errs  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_rd = '0; exp_e = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if ({a_rvalid, a_err, a_rdata} !== {1'b1, exp_e, exp_rd}) begin
          n_fail++; $display("FAIL err_resp_%0d: got v=%b e=%b d=%h expected 1/%b/%h",
                             i - 1, a_rvalid, a_err, a_rdata, exp_e, exp_rd);
        end
      end
      if (i < 5) begin
        drive_a(wes[i], sizes[i], 1'b0, addrs[i], 32'h5566_7788);
        #1;
        n_checks++;
        if ({a_gnt, bank_we} !== {1'b1, (wes[i] && !errs[i]) ? 4'hF : 4'h0}) begin
          n_fail++; $display("FAIL err_we_%0d: got gnt=%b we=%b", i, a_gnt, bank_we);
        end
        exp_e  = errs[i];
        exp_rd = (wes[i] || errs[i]) ? 32'h0 : model_load(addrs[i], sizes[i], 1'b0);
        if (wes[i] && !errs[i]) model_store(addrs[i], sizes[i], 32'h5566_7788);
      end else begin
        a_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_a(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    #1;
    n_checks++;
    if (a_gnt !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gnt: got %b expected 1", a_gnt);
    end
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0;
    #1;
    n_checks++;
    if ({a_rvalid, b_rvalid, a_rdata} !== 34'h0) begin
      n_fail++; $display("FAIL midrst_n1: got v=%b/%b d=%h expected 0/0/0", a_rvalid, b_rvalid, a_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({a_rvalid, b_rvalid} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_n2: got %b expected 00", {a_rvalid, b_rvalid});
    end
    @(negedge clk);
    a_req = 1'b1; b_req = 1'b1; b_we = 1'b0; b_size = 2'd0; b_addr = 32'h1;
    #1;
    n_checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL midrst_first_arb: got a=%b b=%b expected a=1 b=0", a_gnt, b_gnt);
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic rand_req(output logic we, output logic [1:0] size, output logic uns,
                          output logic [31:0] addr, output logic [31:0] wdata);
    we    = $urandom_range(0, 1);
    size  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    uns   = $urandom_range(0, 1);
    wdata = $urandom;
    case ($urandom_range(0, 9))
      0:       addr = 32'(4*DEPTH) - $urandom_range(1, 8);
      1:       addr = 32'hFFFF_FFFF - $urandom_range(0, 4);
      default: addr = $urandom_range(0, 47);
    endcase
  endtask

  task automatic test_random();
    logic        pa, pb, last_b, ega, egb, rv, ro, re, we, uns, err;
    logic [1:0]  sz;
    logic [31:0] ad, wd, rd, ewd, ewm;
    logic [3:0]  emask;
    logic [127:0] enum_v;
    do_reset();
    pa = 0; pb = 0; last_b = 1; rv = 0; ro = 0; re = 0; rd = '0;
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      n_checks++;
      if ({a_rvalid, a_err, a_rdata} !== {rv && !ro, rv && !ro && re, (rv && !ro) ? rd : 32'h0}) begin
        n_fail++; $display("FAIL rand_resp_a cyc %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                           c, a_rvalid, a_err, a_rdata, rv && !ro, re, rd);
      end
      n_checks++;
      if ({b_rvalid, b_err, b_rdata} !== {rv && ro, rv && ro && re, (rv && ro) ? rd : 32'h0}) begin
        n_fail++; $display("FAIL rand_resp_b cyc %0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                           c, b_rvalid, b_err, b_rdata, rv && ro, re, rd);
      end
      if (c == 400) break;
      if (!pa && $urandom_range(0, 3) != 0) begin
        rand_req(a_we, a_size, a_unsigned, a_addr, a_wdata); pa = 1;
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        rand_req(b_we, b_size, b_unsigned, b_addr, b_wdata); pb = 1;
      end
      a_req = pa; b_req = pb;
      #1;
      ega = pa && (!pb || last_b);
      egb = pb && (!pa || !last_b);
      n_checks++;
      if ({a_gnt, b_gnt} !== {ega, egb}) begin
        n_fail++; $display("FAIL rand_gnt cyc %0d: got a=%b b=%b expected a=%b b=%b",
                           c, a_gnt, b_gnt, ega, egb);
      end
      rv = ega || egb;
      if (rv) begin
        we  = egb ? b_we : a_we;       sz = egb ? b_size : a_size;
        uns = egb ? b_unsigned : a_unsigned;
        ad  = egb ? b_addr : a_addr;   wd = egb ? b_wdata : a_wdata;
        err = model_err(ad, sz);
        model_lanes(ad, sz, wd, emask, enum_v, ewd, ewm);
        n_checks++;
        if (bank_we !== ((we && !err) ? emask : 4'h0)) begin
          n_fail++; $display("FAIL rand_bank_we cyc %0d: got %b expected %b addr %h size %0d",
                             c, bank_we, (we && !err) ? emask : 4'h0, ad, sz);
        end
        if (!err) begin
          n_checks++;
          if (bank_num !== enum_v) begin
            n_fail++; $display("FAIL rand_bank_num cyc %0d: got %h expected %h", c, bank_num, enum_v);
          end
          if (we) begin
            n_checks++;
            if ((bank_wdata & ewm) !== ewd) begin
              n_fail++; $display("FAIL rand_bank_wdata cyc %0d: got %h expected %h (mask %h)",
                                 c, bank_wdata, ewd, ewm);
            end
          end
        end
        rd = (we || err) ? 32'h0 : model_load(ad, sz, uns);
        if (we && !err) model_store(ad, sz, wd);
        ro = egb; re = err; last_b = egb;
        if (egb) pb = 0; else pa = 0;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_size = 2'd0; a_unsigned = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_size = 2'd0; b_unsigned = 1'b0; b_addr = '0; b_wdata = '0;
    test_reset();
    test_directed();
    test_arbitration();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lane_arbiter.md
Name: dmem_lane_arbiter

Overview:
- Front-end controller for the four byte-lane data banks (ram0..ram3). Lane j holds every byte whose address has addr[1:0]==j, at word index addr>>2.
- Arbitrates two requesters (A = CPU load/store unit, B = loader/debug port) onto port 1 of the banks using round-robin.
- Steers and sign-extends the read data. Supports byte, half and word accesses at any alignment.
- One access is issued per cycle. The response arrives exactly one cycle after the grant.

Parameters:
- DEPTH, 8192, number of byte entries per lane. Valid word index range is 0..DEPTH-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- a_req, b_req  input  1  request valid (per requester; prefix x below = a or b)
- x_we  input  1  1 = store, 0 = load
- x_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- x_unsigned  input  1  zero-extend loads when 1
- x_addr  input  32  byte address
- x_wdata  input  32  store data, little-endian, LSB at x_addr
- x_gnt  output  1  request accepted this cycle (combinational)
- x_rvalid  output  1  response valid (registered)
- x_rdata  output  32  load result, valid while x_rvalid
- x_err  output  1  access error, valid while x_rvalid
- bank_we  output  4  write enable per lane, bit j = lane j
- bank_num  output  128  word index per lane, bits [32j+31:32j]
- bank_wdata  output  32  write byte per lane, bits [8j+7:8j]
- bank_rdata  input  32  registered read byte per lane (bank r_data1)

Behaviour:
- Reset (rst=1 at a rising edge): a_rvalid=b_rvalid=0, a_err=b_err=0, a_rdata=b_rdata=0, priority pointer set to "last granted = B" so A wins first.
- During any cycle with rst=1: both gnt=0 and bank_we=0.
- Arbitration:
  - Only one requester asserting req: it is granted.
  - Both asserting: the requester not granted last is granted. The pointer updates on every grant.
  - Ungranted requesters hold their request fields stable until granted.
- Byte count n = 1/2/4 for size 0/1/2. For byte k (0..n-1): address p = x_addr+k, lane p[1:0], index p>>2.
- Lanes not touched by the access: bank_we=0; drive index x_addr>>2 so they harmlessly read.
- Store: bank_we[lane]=1 and bank_wdata[lane]=x_wdata[8k+7:8k] for each touched lane.
- Misaligned accesses complete in one cycle. Each lane gets its own index, e.g. word at 0x6 uses index 1 on lanes 2,3 and index 2 on lanes 0,1.
- Error: size==3, or any touched byte has index >= DEPTH, or address arithmetic overflows 32 bits.
  - On error all bank_we=0.
  - The response is still returned, with err=1 and rdata=0.
- Response pipeline:
  - Registers capture {owner, size, unsigned, addr[1:0], is_load, err} at grant cycle N.
  - In cycle N+1, owner's rvalid=1 (one cycle pulse) for both loads and stores. Stores return rdata=0.
  - Load: byte k = bank_rdata[lane (addr+k)[1:0]]. Assembled little-endian, then sign-extended from bit 8n-1 unless unsigned.
  - x_rdata/x_err are combinational from the captured state and bank_rdata during N+1. They are 0 when that requester's rvalid=0.
- Back-to-back: a new grant in N+1 is allowed while response N is presented. Throughput is 1 access/cycle.
- Read-after-write to the same byte in consecutive cycles returns the new data (bank write precedes next read edge).
- Reset mid-operation: a grant in cycle N followed by rst in N+1 suppresses the response. rvalid=0 and the pending response is discarded.

Test Plan:
- Word store A addr 0x6 wdata 0xAABBCCDD -> bank_we=4'b1111; lanes 2,3 index 1 get DD,CC; lanes 0,1 index 2 get BB,AA. Word load 0x6 next cycle -> a_rvalid=1, a_rdata=0xAABBCCDD, a_err=0.
- Byte load 0x7 signed after above -> 0xFFFFFFCC; same with unsigned=1 -> 0x000000CC. Half load 0x5 signed from lanes 1,2 holding 0x00,0xDD -> 0xFFFFDD00.
- a_req and b_req held high 6 cycles after reset -> grants A,B,A,B,A,B. Each rvalid appears one cycle after its grant, to the correct owner only.
- Word store to addr 4*DEPTH-2 -> bank_we=0; next cycle err=1, rdata=0. size=3 load -> err=1. Request issued with rst=1 -> gnt=0, no rvalid.
- Grant load at cycle N, rst asserted in N+1 -> no rvalid in N+1 or later. After release, A wins first contested arbitration.
